spi_ram: RTL

Single-port synchronous memory sitting directly downstream of the SPI slave. Decodes the 10-bit command words the slave delivers on rx_data/rx_valid, maintains separate write and read address pointers, writes memory, and returns read bytes on tx_data/tx_valid. The slave serializes tx_data onto MISO while tx_valid is high.

---
 rtl/spi_ram_pkg.sv | 14 +
 rtl/spi_ram_if.sv | 20 ++
 rtl/spi_ram_mem.sv | 32 +++
 rtl/spi_ram.sv | 117 +++++++++++
 4 files changed

// File: rtl/spi_ram_pkg.sv
// rtl/spi_ram_pkg.sv - opcodes and hold-FSM encodings shared by spi_ram files
package spi_ram_pkg;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } hold_state_e;

endpackage

// File: rtl/spi_ram_if.sv
// rtl/spi_ram_if.sv - command/response bus between the SPI slave and spi_ram
interface spi_ram_if;

  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       rd_err;

  modport master (
    output rx_data, rx_valid,
    input  tx_data, tx_valid, rd_err
  );

  modport slave (
    input  rx_data, rx_valid,
    output tx_data, tx_valid, rd_err
  );

endinterface

// File: rtl/spi_ram_mem.sv
// rtl/spi_ram_mem.sv - single-port byte storage, synchronous write, registered read
module spi_ram_mem #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  // Storage is deliberately left out of reset so contents survive it.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata <= 8'h00;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/spi_ram.sv
// rtl/spi_ram.sv - command decoder, address pointers and tx hold FSM for SPI RAM
module spi_ram
  import spi_ram_pkg::*;
#(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8,
  parameter int AUTO_INC  = 0,
  parameter int TX_HOLD   = 9
) (
  input logic      clk,
  input logic      rst_n,
  spi_ram_if.slave bus
);

  localparam logic [3:0] HOLD_LOAD = 4'(TX_HOLD);

  logic                 rx_prev;
  logic                 fire;
  logic                 wr_fire;
  logic                 rd_fire;
  logic [1:0]           opcode;
  logic [7:0]           payload;
  logic [ADDR_SIZE-1:0] wr_addr;
  logic [ADDR_SIZE-1:0] rd_addr;
  logic [ADDR_SIZE-1:0] mem_addr;
  logic                 rd_armed;
  logic                 rd_err_q;
  hold_state_e          state;
  logic [3:0]           cnt;
  logic                 tx_valid_q;
  logic [7:0]           tx_data_q;

  assign opcode  = bus.rx_data[9:8];
  assign payload = bus.rx_data[7:0];
  assign fire    = bus.rx_valid & ~rx_prev;
  assign wr_fire = fire && (opcode == CMD_WR_DATA);
  assign rd_fire = fire && (opcode == CMD_RD_DATA);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_prev <= 1'b0;
    end else begin
      rx_prev <= bus.rx_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_addr  <= '0;
      rd_addr  <= '0;
      rd_armed <= 1'b0;
      rd_err_q <= 1'b0;
    end else if (fire) begin
      case (opcode)
        CMD_WR_ADDR: wr_addr <= payload[ADDR_SIZE-1:0];
        CMD_WR_DATA: begin
          if (AUTO_INC != 0) wr_addr <= wr_addr + 1'b1;
        end
        CMD_RD_ADDR: begin
          rd_addr  <= payload[ADDR_SIZE-1:0];
          rd_armed <= 1'b1;
        end
        default: begin
          if (!rd_armed) rd_err_q <= 1'b1;
          if (AUTO_INC != 0) rd_addr <= rd_addr + 1'b1;
        end
      endcase
    end
  end

  // One command per edge, so the single port is shared by address mux.
  assign mem_addr = rd_fire ? rd_addr : wr_addr;

  spi_ram_mem #(
    .DEPTH (MEM_DEPTH),
    .AW    (ADDR_SIZE)
  ) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_fire),
    .re    (rd_fire),
    .addr  (mem_addr),
    .wdata (payload),
    .rdata (tx_data_q)
  );

  // A read in SEND reloads the counter so tx_valid never drops between reads.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= 4'd0;
      tx_valid_q <= 1'b0;
    end else if (rd_fire) begin
      state      <= ST_SEND;
      cnt        <= HOLD_LOAD;
      tx_valid_q <= 1'b1;
    end else begin
      case (state)
        ST_SEND: begin
          if (cnt == 4'd1) begin
            state      <= ST_IDLE;
            cnt        <= 4'd0;
            tx_valid_q <= 1'b0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: tx_valid_q <= 1'b0;
      endcase
    end
  end

  assign bus.tx_data  = tx_data_q;
  assign bus.tx_valid = tx_valid_q;
  assign bus.rd_err   = rd_err_q;

endmodule
